// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for decode_stage
interface decode_stage_if #(parameter int PC_WIDTH = 32);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [PC_WIDTH-1:0] in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [6:0]          out_opcode;
    logic [2:0]          out_func3;
    logic [6:0]          out_func7;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [4:0]          out_rd;
    logic [31:0]         out_imm;
    logic                out_illegal;
    logic                out_is_ecall;
    logic                out_is_ebreak;
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_imm, out_illegal, out_is_ecall, out_is_ebreak
    );
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_imm, out_illegal, out_is_ecall, out_is_ebreak
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with output FIFO and flush.
// Define RV32M_EN to accept OP-class M-extension encodings (func7 = 0000001).
module decode_stage #(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    input logic           flush,
    decode_stage_if.slave io
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif
    localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_BRANCH = 7'h63, OP_JALR = 7'h67;
    localparam logic [6:0] OP_JAL = 7'h6f, OP_IMM = 7'h13, OP_REG = 7'h33, OP_LUI = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17, OP_MISC = 7'h0f, OP_SYSTEM = 7'h73;
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [31:0]         imm;
        logic                illegal;
        logic                is_ecall;
        logic                is_ebreak;
    } rec_t;
    logic [31:0]   i;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          ill;
    logic [31:0]   imm_raw;
    rec_t          rec;
    rec_t          head;
    rec_t          mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    assign i  = io.in_instr;
    assign op = i[6:0];
    assign f3 = i[14:12];
    assign f7 = i[31:25];
    // Unknown opcodes (including any word whose low bits are not 11) fall to the default arm.
    always_comb begin
        ill     = 1'b0;
        imm_raw = '0;
        case (op)
            OP_LOAD: begin
                ill     = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                imm_raw = {{20{i[31]}}, i[31:20]};
            end
            OP_STORE: begin
                ill     = !(f3 inside {3'b000, 3'b001, 3'b010});
                imm_raw = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            OP_BRANCH: begin
                ill     = f3 inside {3'b010, 3'b011};
                imm_raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            OP_JALR: begin
                ill     = f3 != 3'b000;
                imm_raw = {{20{i[31]}}, i[31:20]};
            end
            OP_JAL:   imm_raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OP_LUI, OP_AUIPC: imm_raw = {i[31:12], 12'b0};
            OP_IMM: begin
                ill     = (f3 == 3'b001 && f7 != 7'h00) ||
                          (f3 == 3'b101 && !(f7 inside {7'h00, 7'h20}));
                imm_raw = {{20{i[31]}}, i[31:20]};
            end
            OP_REG:    ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'b000, 3'b101}) ||
                               (M_EN && f7 == 7'h01));
            OP_MISC:   ill = f3 != 3'b000;
            OP_SYSTEM: ill = f3 == 3'b100 ||
                             (f3 == 3'b000 && i != 32'h0000_0073 && i != 32'h0010_0073);
            default:   ill = 1'b1;
        endcase
    end
    always_comb begin
        rec.pc        = io.in_pc;
        rec.opcode    = op;
        rec.func3     = f3;
        rec.func7     = f7;
        rec.rs1       = i[19:15];
        rec.rs2       = i[24:20];
        rec.rd        = i[11:7];
        rec.imm       = ill ? '0 : imm_raw;
        rec.illegal   = ill;
        rec.is_ecall  = i == 32'h0000_0073;
        rec.is_ebreak = i == 32'h0010_0073;
    end
    assign io.in_ready  = count < CW'(DEPTH);
    assign io.out_valid = count != '0;
    assign push = io.in_valid && io.in_ready;
    assign pop  = io.out_valid && io.out_ready;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= rec;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = io.out_valid ? mem[rptr] : '0;
    assign io.out_pc        = head.pc;
    assign io.out_opcode    = head.opcode;
    assign io.out_func3     = head.func3;
    assign io.out_func7     = head.func7;
    assign io.out_rs1       = head.rs1;
    assign io.out_rs2       = head.rs2;
    assign io.out_rd        = head.rd;
    assign io.out_imm       = head.imm;
    assign io.out_illegal   = head.illegal;
    assign io.out_is_ecall  = head.is_ecall;
    assign io.out_is_ebreak = head.is_ebreak;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a queue-based reference.
module tb_decode_stage;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [63:0] q[$];
    logic [6:0]  ops [11] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h13, 7'h33, 7'h37, 7'h17, 7'h0f, 7'h73};
    decode_stage_if #(.PC_WIDTH(32)) bus ();
    decode_stage #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .io    (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic void ref_decode(input logic [31:0] i, output logic [31:0] imm, output logic ill);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       m;
        f3 = i[14:12];
        f7 = i[31:25];
`ifdef RV32M_EN
        m = 1'b1;
`else
        m = 1'b0;
`endif
        imm = 32'h0;
        case (i[6:0])
            7'h03: begin ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); imm = 32'($signed(i) >>> 20); end
            7'h23: begin ill = !(f3 inside {3'd0, 3'd1, 3'd2}); imm = (32'($signed(i) >>> 20) & ~32'h1f) | 32'(i[11:7]); end
            7'h63: begin ill = f3 inside {3'd2, 3'd3}; imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
            7'h67: begin ill = f3 != 3'd0; imm = 32'($signed(i) >>> 20); end
            7'h6f: begin ill = 1'b0; imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
            7'h13: begin
                ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && !(f7 inside {7'd0, 7'd32}));
                imm = 32'($signed(i) >>> 20);
            end
            7'h33: ill = !(f7 == 7'd0 || (f7 == 7'd32 && f3 inside {3'd0, 3'd5}) || (m && f7 == 7'd1));
            7'h37, 7'h17: begin ill = 1'b0; imm = i & 32'hffff_f000; end
            7'h0f: ill = f3 != 3'd0;
            7'h73: ill = f3 == 3'd4 || (f3 == 3'd0 && !(i inside {32'h73, 32'h0010_0073}));
            default: ill = 1'b1;
        endcase
        if (ill) imm = 32'h0;
    endfunction
    task automatic compare_model();
        logic [31:0] ins;
        logic [31:0] eimm;
        logic        eill;
        check("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            ins = q[0][31:0];
            ref_decode(ins, eimm, eill);
            check("pc", 64'(bus.out_pc), 64'(q[0][63:32]));
            check("opcode", 64'(bus.out_opcode), 64'(ins[6:0]));
            check("func3", 64'(bus.out_func3), 64'(ins[14:12]));
            check("func7", 64'(bus.out_func7), 64'(ins[31:25]));
            check("rs1", 64'(bus.out_rs1), 64'(ins[19:15]));
            check("rs2", 64'(bus.out_rs2), 64'(ins[24:20]));
            check("rd", 64'(bus.out_rd), 64'(ins[11:7]));
            check("imm", 64'(bus.out_imm), 64'(eimm));
            check("illegal", 64'(bus.out_illegal), 64'(eill));
            check("ecall", 64'(bus.out_is_ecall), 64'(!eill && ins == 32'h73));
            check("ebreak", 64'(bus.out_is_ebreak), 64'(!eill && ins == 32'h0010_0073));
        end else begin
            check("zero_lo", {bus.out_imm, bus.out_pc}, 64'h0);
            check("zero_hi", 64'({bus.out_opcode, bus.out_func3, bus.out_func7, bus.out_rs1, bus.out_rs2,
                                  bus.out_rd, bus.out_illegal, bus.out_is_ecall, bus.out_is_ebreak}), 64'h0);
        end
    endtask
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic rst);
        logic push;
        logic pop;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        flush         = fl;
        reset         = rst;
        @(negedge clk);
        compare_model();
        push = v && q.size() < DEPTH;
        pop  = q.size() != 0 && rdy;
        @(posedge clk);
        if (rst || fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({pc, ins});
        end
        #1;
    endtask
    initial begin
        logic        mul_ill;
        logic [31:0] ins;
`ifdef RV32M_EN
        mul_ill = 1'b0;
`else
        mul_ill = 1'b1;
`endif
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        step(1, 32'h0050_0093, 32'h100, 1, 0, 0);
        check("addi_valid", 64'(bus.out_valid), 64'd1);
        check("addi_rd", 64'(bus.out_rd), 64'd1);
        check("addi_rs1", 64'(bus.out_rs1), 64'd0);
        check("addi_imm", 64'(bus.out_imm), 64'h5);
        check("addi_ill", 64'(bus.out_illegal), 64'd0);
        check("addi_pc", 64'(bus.out_pc), 64'h100);
        step(1, 32'h4020_81b3, 32'h104, 1, 0, 0);
        check("sub_ill", 64'(bus.out_illegal), 64'd0);
        check("sub_f7", 64'(bus.out_func7), 64'h20);
        check("sub_imm", 64'(bus.out_imm), 64'h0);
        step(1, 32'h2020_81b3, 32'h108, 1, 0, 0);
        check("badf7_ill", 64'(bus.out_illegal), 64'd1);
        step(1, 32'hfe00_0ee3, 32'h10c, 1, 0, 0);
        check("beq_imm", 64'(bus.out_imm), 64'hffff_fffc);
        step(1, 32'h0000_0073, 32'h110, 1, 0, 0);
        check("ecall", 64'(bus.out_is_ecall), 64'd1);
        check("ecall_ebreak", 64'(bus.out_is_ebreak), 64'd0);
        step(1, 32'h0000_0000, 32'h114, 1, 0, 0);
        check("zero_ill", 64'(bus.out_illegal), 64'd1);
        check("zero_imm", 64'(bus.out_imm), 64'h0);
        step(1, 32'h0273_02b3, 32'h118, 1, 0, 0);
        check("mul_ill", 64'(bus.out_illegal), 64'(mul_ill));
        step(0, 0, 0, 1, 0, 0);
        check("drained", 64'(bus.out_valid), 64'd0);
        step(1, 32'h0010_0093, 32'h200, 0, 0, 0);
        step(1, 32'h0020_0093, 32'h204, 0, 0, 0);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        step(1, 32'h0030_0093, 32'h208, 0, 0, 0);
        check("held_in_ready", 64'(bus.in_ready), 64'd0);
        check("held_head", 64'(bus.out_pc), 64'h200);
        step(1, 32'h0030_0093, 32'h208, 1, 0, 0);
        check("drain1_head", 64'(bus.out_pc), 64'h204);
        step(1, 32'h0030_0093, 32'h208, 1, 0, 0);
        check("drain2_head", 64'(bus.out_pc), 64'h208);
        step(0, 0, 0, 1, 0, 0);
        check("drain3_empty", 64'(bus.out_valid), 64'd0);
        step(1, 32'h0010_0093, 32'h300, 0, 0, 0);
        step(1, 32'h0020_0093, 32'h304, 0, 0, 0);
        step(1, 32'h0040_0093, 32'h308, 0, 1, 0);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ready", 64'(bus.in_ready), 64'd1);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h0010_0093, 32'h400, 0, 0, 0);
        step(1, 32'h0040_0093, 32'h404, 0, 1, 0);
        check("flush_drop", 64'(bus.out_valid), 64'd0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h0010_0093, 32'h500, 0, 0, 0);
        step(1, 32'h0020_0093, 32'h504, 0, 1, 1);
        check("rstflush_valid", 64'(bus.out_valid), 64'd0);
        check("rstflush_ready", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 600; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) == 0) ins[31:25] = ($urandom_range(0, 2) == 0) ? 7'h01 :
                                                        ($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00;
            if ($urandom_range(0, 19) == 0) ins = ($urandom_range(0, 1) == 0) ? 32'h73 : 32'h0010_0073;
            step(logic'($urandom_range(0, 9) < 7), ins, $urandom, logic'($urandom_range(0, 9) < 6),
                 logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 99) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Sits between fetch and execute, with valid/ready handshakes on both sides and an output FIFO of configurable depth.
- Decodes full RV32I field and immediate extraction with strict legality checking: func3/func7 checks per opcode, plus ECALL/EBREAK identification.
- Supports pipeline flush, and optional RV32M legality via a macro.

Parameters:
- DEPTH, 2, output FIFO entries; power of two, minimum 2.
- PC_WIDTH, 32, width of the program counter carried alongside each instruction.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction word
- in_pc  in  PC_WIDTH  address of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_pc  out  PC_WIDTH  pc of head
- out_opcode  out  7  instr[6:0]
- out_func3  out  3  instr[14:12]
- out_func7  out  7  instr[31:25]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_rd  out  5  instr[11:7]
- out_imm  out  32  sign-extended immediate per format
- out_illegal  out  1  instruction failed legality check
- out_is_ecall  out  1  exactly 0x00000073
- out_is_ebreak  out  1  exactly 0x00100073

Behaviour:
- Reset: the FIFO count, read pointer and write pointer go to 0, and out_valid=0.
  - All out_* data fields read 0 while out_valid=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Push occurs when in_valid and in_ready are both high. Decode is combinational on in_instr; the decoded record is written into the FIFO at the push edge.
- Latency: a word accepted on edge N appears at the head with out_valid=1 from edge N onward, i.e. visible in cycle N+1 if the FIFO was empty.
- Pop occurs when out_valid and out_ready are both high; the next entry is shown in the following cycle.
- in_ready = (count < DEPTH). There is no combinational path from out_ready to in_ready: a full FIFO deasserts in_ready even when a pop is occurring.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, and both pointers advance modulo DEPTH.
- Flush: count and both pointers go to 0 at the edge. Flush takes priority over a push or pop in the same cycle, so the pushed word is dropped. out_valid=0 in the next cycle.
- reset has priority over flush.
- Immediate selection by opcode:
  - JALR, LOAD, OP_IMM: I-type.
  - STORE: S-type.
  - BRANCH: B-type, bit0 = 0.
  - LUI, AUIPC: U-type, low 12 bits = 0.
  - JAL: J-type, bit0 = 0.
  - All other opcodes, and any instruction with illegal=1: imm = 0.
- Legality: illegal=1 if instr[1:0] != 11 or the opcode is unknown. Otherwise, per opcode:
  - LOAD: func3 must be in {000, 001, 010, 100, 101}.
  - STORE: func3 must be in {000, 001, 010}.
  - BRANCH: func3 must not be 010 or 011.
  - JALR: func3 must be 000.
  - OP: func7 must be 0000000; or func7 = 0100000 with func3 in {000, 101}.
  - OP_IMM: func3 001 requires func7 = 0000000; func3 101 requires func7 in {0000000, 0100000}.
  - MEM_MISC: func3 must be 000.
  - SYSTEM: func3 = 000 is legal only for ECALL/EBREAK; func3 = 100 is illegal; all other func3 values are legal (CSR).
  - LUI, AUIPC, JAL: always legal.
- Illegal instructions are still queued and delivered, with out_illegal=1, so a trap can be raised downstream.
- out_is_ecall and out_is_ebreak are mutually exclusive; both are 0 when illegal=1.

Optional Feature:
- Macro RV32M_EN.
- Defined: OP with func7 = 0000001 and any func3 is legal, with imm = 0.
- Undefined: OP with func7 = 0000001 sets out_illegal=1.
- No other behaviour differs.

Test Plan:
- addi x1,x0,5 (0x00500093), pc 0x100, out_ready=1 -> out_valid=1 the next cycle; rd=1, rs1=0, imm=0x00000005, illegal=0, out_pc=0x100.
- sub x3,x1,x2 (0x402081B3) -> illegal=0, func7=0x20, imm=0; then 0x202081B3 (func7=0010000) -> illegal=1.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC; ecall 0x00000073 -> is_ecall=1; 0x00000000 -> illegal=1, imm=0.
- DEPTH=2, out_ready=0, three pushes -> in_ready=0 after the second push and the third word is held off; raise out_ready -> first two words drain in order and the third is then accepted.
- With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, count=0, and the pushed word is never output.
- mul x5,x6,x7 (0x027302B3) -> illegal=1 without RV32M_EN; illegal=0 with RV32M_EN.
